// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - EX request, data-memory bus and WB record bundle for mem_lsu
interface mem_lsu_if #(parameter int ADDR_W = 32);
   logic              in_valid;
   logic              in_ready;
   logic              in_load;
   logic              in_store;
   logic [2:0]        in_funct3;
   logic [ADDR_W-1:0] in_addr;
   logic [ADDR_W-1:0] in_wdata;
   logic [4:0]        in_rd;
   logic              in_wen;

   logic              dmem_req;
   logic              dmem_gnt;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [3:0]        dmem_be;
   logic [ADDR_W-1:0] dmem_wdata;
   logic              dmem_rvalid;
   logic [ADDR_W-1:0] dmem_rdata;

   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_data;
   logic [4:0]        out_rd;
   logic              out_wen;
   logic              out_err;

   modport master (
      input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd, in_wen,
      output in_ready,
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata,
      output out_valid, out_data, out_rd, out_wen, out_err,
      input  out_ready
   );

   modport slave (
      output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd, in_wen,
      input  in_ready,
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata,
      input  out_valid, out_data, out_rd, out_wen, out_err,
      output out_ready
   );
endinterface

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - memory-stage load/store unit: dmem request/response, load align, WB handoff
module mem_lsu #(parameter int ADDR_W = 32) (
   input  logic     clk,
   input  logic     rst_n,
   mem_lsu_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ, RSP, OUT} state_t;

   state_t            state_q, state_d;
   logic              in_rdy;
   logic              accept;
   logic              non_mem;
   logic              acc_err;
   logic [1:0]        sz;
   logic [3:0]        be_in;
   logic [ADDR_W-1:0] wd_in;

   logic              is_load_q;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [1:0]        lo_q;
   logic [4:0]        rd_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q;
   logic [ADDR_W-1:0] wdata_q;
   logic [ADDR_W-1:0] out_data_q;
   logic              out_wen_q;
   logic              out_err_q;
   logic [ADDR_W-1:0] sh;
   logic [ADDR_W-1:0] ld_data;

   assign sz      = bus.in_funct3[1:0];
   assign non_mem = !bus.in_load && !bus.in_store;

   always_comb begin
      acc_err = 1'b0;
      if (bus.in_load && bus.in_store)
         acc_err = 1'b1;
      else if (bus.in_load && !(bus.in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
         acc_err = 1'b1;
      else if (bus.in_store && (bus.in_funct3[2] || bus.in_funct3 == 3'b011))
         acc_err = 1'b1;
      if (!non_mem && sz == 2'b01 && bus.in_addr[0])
         acc_err = 1'b1;
      if (!non_mem && sz == 2'b10 && bus.in_addr[1:0] != 2'b00)
         acc_err = 1'b1;
   end

   // Lanes are replicated so the store byte lands on whichever lane be selects.
   always_comb begin
      be_in = 4'b1111;
      wd_in = bus.in_wdata;
      case (sz)
         2'b00: begin
            be_in = 4'b0001 << bus.in_addr[1:0];
            wd_in = {4{bus.in_wdata[7:0]}};
         end
         2'b01: begin
            be_in = 4'b0011 << bus.in_addr[1:0];
            wd_in = {2{bus.in_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      sh      = bus.dmem_rdata >> {lo_q, 3'b000};
      ld_data = sh;
      case (f3_q)
         3'b000:  ld_data = {{24{sh[7]}}, sh[7:0]};
         3'b100:  ld_data = {24'd0, sh[7:0]};
         3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
         3'b101:  ld_data = {16'd0, sh[15:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      in_rdy  = 1'b0;
      accept  = 1'b0;
      case (state_q)
         IDLE: in_rdy = 1'b1;
         REQ:  if (bus.dmem_gnt) state_d = RSP;
         RSP:  if (bus.dmem_rvalid) state_d = OUT;
         OUT: begin
            if (bus.out_ready) begin
               in_rdy  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      accept = in_rdy && bus.in_valid;
      if (accept)
         state_d = (non_mem || acc_err) ? OUT : REQ;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_load_q  <= 1'b0;
         we_q       <= 1'b0;
         f3_q       <= 3'd0;
         lo_q       <= 2'd0;
         rd_q       <= 5'd0;
         addr_q     <= '0;
         be_q       <= 4'd0;
         wdata_q    <= '0;
         out_data_q <= '0;
         out_wen_q  <= 1'b0;
         out_err_q  <= 1'b0;
      end else if (accept) begin
         is_load_q  <= bus.in_load;
         we_q       <= bus.in_store && !acc_err;
         f3_q       <= bus.in_funct3;
         lo_q       <= bus.in_addr[1:0];
         rd_q       <= bus.in_rd;
         addr_q     <= {bus.in_addr[ADDR_W-1:2], 2'b00};
         be_q       <= be_in;
         wdata_q    <= wd_in;
         out_data_q <= non_mem ? bus.in_addr : '0;
         out_wen_q  <= non_mem && bus.in_wen;
         out_err_q  <= acc_err;
      end else if (state_q == RSP && bus.dmem_rvalid) begin
         out_data_q <= is_load_q ? ld_data : '0;
         out_wen_q  <= is_load_q && rd_q != 5'd0;
      end
   end

   assign bus.in_ready   = in_rdy;
   assign bus.dmem_req   = (state_q == REQ);
   assign bus.dmem_we    = we_q;
   assign bus.dmem_addr  = addr_q;
   assign bus.dmem_be    = be_q;
   assign bus.dmem_wdata = wdata_q;
   assign bus.out_valid  = (state_q == OUT);
   assign bus.out_data   = out_data_q;
   assign bus.out_rd     = rd_q;
   assign bus.out_wen    = out_wen_q;
   assign bus.out_err    = out_err_q;
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Memory-stage load/store unit of the 5-stage core, directly downstream of the EX-stage ALU. It consumes the ALU result as an effective address, or as a pass-through value for non-memory ops. It drives a request/grant/response data-memory port with byte lanes, aligns and extends load data, and hands a writeback record to WB over a valid/ready handshake. While a bus transaction is outstanding it stalls EX by deasserting in_ready.

Parameters:
ADDR_W, 32, address and data width; only 32 is supported.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  EX presents an op.
in_ready  out  1  LSU accepts an op this cycle.
in_load  in  1  op is a load.
in_store  in  1  op is a store.
in_funct3  in  3  RV32I size/sign field.
in_addr  in  32  ALU result: effective address, or pass-through value.
in_wdata  in  32  store data (rs2).
in_rd  in  5  destination register.
in_wen  in  1  register write request for non-memory ops.
dmem_req  out  1  bus request.
dmem_gnt  in  1  bus accepts the request.
dmem_we  out  1  1 = write.
dmem_addr  out  32  word-aligned address, {in_addr[31:2],2'b00}.
dmem_be  out  4  byte enables.
dmem_wdata  out  32  lane-replicated store data.
dmem_rvalid  in  1  response or ack; arrives at least 1 cycle after gnt.
dmem_rdata  in  32  read data.
out_valid  out  1  writeback record valid.
out_ready  in  1  WB accepts the record.
out_data  out  32  load result or pass-through value.
out_rd  out  5  destination register.
out_wen  out  1  write rd.
out_err  out  1  misaligned or illegal access; no bus access was made.

Behaviour:
- Reset is asynchronous, active-low. FSM returns to IDLE. All outputs are 0 except in_ready, which is 1.
- Reset mid-transaction drops dmem_req immediately. Any later rvalid is ignored.
- FSM states: IDLE, REQ, RSP, OUT.
- in_ready = (state==IDLE) | (state==OUT & out_ready).
- On accept, the op fields are registered and the next state is chosen:
  - Non-memory op (!in_load & !in_store): OUT, with out_data=in_addr and out_wen=in_wen.
  - Error: OUT, with out_err=1, out_wen=0, and no request issued.
  - Otherwise: REQ.
- Error conditions:
  - in_load & in_store both set.
  - Load funct3 not in {000,001,010,100,101}.
  - Store funct3 not in {000,001,010}.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
- REQ: dmem_req=1. dmem_we, dmem_addr, dmem_be and dmem_wdata come from registers and stay stable until dmem_gnt. On gnt the next state is RSP.
- RSP: wait for dmem_rvalid, then go to OUT.
  - Load: out_data is the extracted value and out_wen=(rd!=0).
  - Store: out_wen=0 and out_data=0.
- Byte enables and write data:
  - Byte: be=4'b0001<<a[1:0]; wdata={4{wdata[7:0]}}.
  - Half: be=4'b0011<<a[1:0]; wdata={2{wdata[15:0]}}.
  - Word: be=4'b1111; wdata unchanged.
  - Loads use the same be as the access size.
- Load extract: sh=rdata>>(8*a[1:0]).
  - LB: sign-extend sh[7:0]. LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0]. LHU: zero-extend sh[15:0].
  - LW: rdata.
- OUT: out_valid=1 with the record held stable until out_ready.
  - On out_ready, a simultaneous in_valid is accepted in the same cycle (back-to-back).
  - Otherwise the next state is IDLE.
- dmem_rvalid outside RSP, and dmem_gnt outside REQ, are ignored.
- out_rd and out_wen are only meaningful while out_valid=1.
- Latency: load accepted in cycle T with gnt at T+1 and rvalid at T+2 gives out_valid at T+3. A non-memory op accepted at T gives out_valid at T+1.

Test Plan:
- LB at addr 0x1003, rdata=0x80FF_1234 -> dmem_addr=0x1000, be=4'b1000, out_data=0xFFFF_FF80, out_wen=1.
- SH at addr 0x2002, in_wdata=0x0000_BEEF -> dmem_we=1, be=4'b1100, dmem_wdata=0xBEEF_BEEF; after rvalid, out_valid=1 with out_wen=0.
- LW at addr 0x0006 -> no dmem_req ever, out_err=1 at T+1, out_wen=0.
- LHU at 0x0002 with gnt held low 3 cycles -> req, addr and be stable for all 4 REQ cycles, in_ready=0 throughout; rdata=0xA5A5_0000 -> out_data=0x0000_A5A5.
- Two non-memory ops back-to-back with out_ready=1 -> second accepted in the OUT cycle of the first, one record per cycle. With out_ready=0 for 2 cycles -> record held and in_ready=0.
- rst_n pulsed low during RSP -> dmem_req=0, out_valid=0 and in_ready=1 asynchronously; a stale rvalid afterwards produces no out_valid.
